// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package memory_arbiter_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Requester identity; also the bit index into the request/grant vectors.
  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } requester_e;

  // Memory command encoding, shared with the memory controller.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last. Purely combinational.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (last_grant == DMA) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between the core and a DMA/debug master. One
// transaction outstanding at a time, round-robin on ties, and a watchdog that
// ends a transaction with an error if memory never completes it. Ready never
// looks at enable, so requesters may derive enable from ready.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    core_req,
  input  logic                    core_enable,
  input  logic                    core_command,
  input  logic [ADDR_WIDTH-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]   core_write_data,
  input  logic [DATA_WIDTH/8-1:0] core_write_mask,
  output logic                    core_ready,
  output logic                    core_valid,
  output logic                    core_error,
  input  logic                    dma_req,
  input  logic                    dma_enable,
  input  logic                    dma_command,
  input  logic [ADDR_WIDTH-1:0]   dma_address,
  input  logic [DATA_WIDTH-1:0]   dma_write_data,
  input  logic [DATA_WIDTH/8-1:0] dma_write_mask,
  output logic                    dma_ready,
  output logic                    dma_valid,
  output logic                    dma_error,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    mem_ready,
  output logic                    mem_enable,
  output logic                    mem_command,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_mask,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  localparam int                     MASK_WIDTH = DATA_WIDTH / 8;
  localparam bit                     WD_ON      = (TIMEOUT_CYCLES != 0);
  localparam logic [COUNT_WIDTH-1:0] WD_LAST    = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] WD_MAX     = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] WD_ONE     = COUNT_WIDTH'(1);

  state_e                 state_r, state_nxt_s;
  requester_e             owner_r, owner_nxt_s;
  requester_e             last_grant_r, last_grant_nxt_s;
  logic [COUNT_WIDTH-1:0] wd_count_r, wd_count_nxt_s;

  logic [1:0] req_s;
  logic [1:0] grant_raw_s;
  logic [1:0] grant_s;
  logic       core_ready_s, dma_ready_s;
  logic       accept_core_s, accept_dma_s, accept_s;
  logic       done_s, timeout_s;
  logic       core_valid_s, dma_valid_s, core_error_s, dma_error_s;

  assign req_s = {dma_req, core_req};

  rr_arbiter2 u_rr (
    .req        (req_s),
    .last_grant (last_grant_r),
    .grant      (grant_raw_s)
  );

  // Per-cycle decode: who may transfer, who transfers, and how a busy
  // transaction ends. A real completion beats a timeout on the same cycle.
  always_comb begin
    grant_s       = (state_r == IDLE) ? grant_raw_s : 2'b00;
    core_ready_s  = grant_s[CORE] & mem_ready;
    dma_ready_s   = grant_s[DMA]  & mem_ready;
    accept_core_s = core_ready_s & core_enable;
    accept_dma_s  = dma_ready_s  & dma_enable;
    accept_s      = accept_core_s | accept_dma_s;
    done_s        = (state_r == BUSY) & mem_valid;
    timeout_s     = WD_ON & (state_r == BUSY) & ~mem_valid & (wd_count_r == WD_LAST);
    core_valid_s  = (done_s | timeout_s) & (owner_r == CORE);
    dma_valid_s   = (done_s | timeout_s) & (owner_r == DMA);
    core_error_s  = timeout_s & (owner_r == CORE);
    dma_error_s   = timeout_s & (owner_r == DMA);
  end

  // Next-state logic for the control FSM, owner tracking and watchdog.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_grant_nxt_s = last_grant_r;
    wd_count_nxt_s   = wd_count_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s      = BUSY;
          owner_nxt_s      = accept_dma_s ? DMA : CORE;
          last_grant_nxt_s = accept_dma_s ? DMA : CORE;
          wd_count_nxt_s   = {COUNT_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (wd_count_r != WD_MAX) begin
          wd_count_nxt_s = wd_count_r + WD_ONE;
        end else begin
          wd_count_nxt_s = wd_count_r;
        end
        if (mem_valid) begin
          state_nxt_s = IDLE;
        end else if (timeout_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DRAIN: begin
        // The abandoned transaction's completion is swallowed here.
        if (mem_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset leaves the core as winner of the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      owner_r      <= CORE;
      last_grant_r <= DMA;
      wd_count_r   <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      wd_count_r   <= wd_count_nxt_s;
    end
  end

  // Output drive: everything is held at zero while reset is asserted; the
  // memory command fields follow the granted requester, else the core.
  always_comb begin
    core_ready     = 1'b0;
    core_valid     = 1'b0;
    core_error     = 1'b0;
    dma_ready      = 1'b0;
    dma_valid      = 1'b0;
    dma_error      = 1'b0;
    read_data      = {DATA_WIDTH{1'b0}};
    mem_enable     = 1'b0;
    mem_command    = MEM_READ;
    mem_address    = {ADDR_WIDTH{1'b0}};
    mem_write_data = {DATA_WIDTH{1'b0}};
    mem_write_mask = {MASK_WIDTH{1'b0}};
    if (reset_n) begin
      core_ready = core_ready_s;
      core_valid = core_valid_s;
      core_error = core_error_s;
      dma_ready  = dma_ready_s;
      dma_valid  = dma_valid_s;
      dma_error  = dma_error_s;
      read_data  = mem_read_data;
      mem_enable = accept_s;
      if (grant_s[DMA]) begin
        mem_command    = dma_command;
        mem_address    = dma_address;
        mem_write_data = dma_write_data;
        mem_write_mask = dma_write_mask;
      end else begin
        mem_command    = core_command;
        mem_address    = core_address;
        mem_write_data = core_write_data;
        mem_write_mask = core_write_mask;
      end
    end else begin
      mem_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios followed by random traffic.
// Expected completions are queued when a transfer is accepted and checked by
// an independent monitor; readiness and command muxing are checked per cycle.
`timescale 1ns/1ps
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic        req;
    logic        en;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } rq_t;

  typedef struct {
    int          who;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic core_req, core_enable, core_command, dma_req, dma_enable, dma_command;
  logic [31:0] core_address, core_write_data, dma_address, dma_write_data;
  logic [3:0]  core_write_mask, dma_write_mask;
  logic core_ready, core_valid, core_error, dma_ready, dma_valid, dma_error;
  logic [31:0] read_data, mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic mem_ready, mem_enable, mem_command, mem_valid;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_enable(core_enable), .core_command(core_command),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_write_mask(core_write_mask), .core_ready(core_ready),
    .core_valid(core_valid), .core_error(core_error),
    .dma_req(dma_req), .dma_enable(dma_enable), .dma_command(dma_command),
    .dma_address(dma_address), .dma_write_data(dma_write_data),
    .dma_write_mask(dma_write_mask), .dma_ready(dma_ready),
    .dma_valid(dma_valid), .dma_error(dma_error),
    .read_data(read_data), .mem_ready(mem_ready), .mem_enable(mem_enable),
    .mem_command(mem_command), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .mem_valid(mem_valid), .mem_read_data(mem_read_data)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int free_at = 0;       // first cycle the port is free again
  int resp_cycle = 0;    // cycle the bench memory answers
  int last_served = 1;   // 0 = core, 1 = dma
  int n_mem_en = 0;
  logic [31:0] resp_data = 32'h0;
  exp_t exp_q[$];
  int dut_grants[$];
  exp_t mon_e;
  rq_t s_core, s_dma;
  logic s_mr = 1'b1;
  logic s_stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rq_t mk_rq(input logic req, input logic en, input logic cmd,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask);
    rq_t r;
    r.req = req; r.en = en; r.cmd = cmd; r.addr = addr; r.wdata = wdata; r.mask = mask;
    return r;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, 32'({core_ready, core_valid, core_error, dma_ready,
                                 dma_valid, dma_error, mem_enable, mem_command}), 32'd0);
    check({name, "_addr"}, mem_address, 32'd0);
    check({name, "_wdata"}, mem_write_data, 32'd0);
    check({name, "_mask"}, 32'(mem_write_mask), 32'd0);
    check({name, "_rdata"}, read_data, 32'd0);
  endtask

  // One clock of stimulus plus the reference model's view of that cycle.
  // lat = 0 picks a random latency 1..6 and random read data.
  task automatic run_cycle(input int lat, input logic [31:0] rdata);
    int winner;
    int l;
    bit acc;
    rq_t ef;
    @(posedge clk); #1;
    cyc++;
    core_req = s_core.req; core_enable = s_core.en; core_command = s_core.cmd;
    core_address = s_core.addr; core_write_data = s_core.wdata; core_write_mask = s_core.mask;
    dma_req = s_dma.req; dma_enable = s_dma.en; dma_command = s_dma.cmd;
    dma_address = s_dma.addr; dma_write_data = s_dma.wdata; dma_write_mask = s_dma.mask;
    mem_ready = s_mr;
    if (cyc < free_at) begin
      mem_valid = (cyc == resp_cycle);
      mem_read_data = (cyc == resp_cycle) ? resp_data : $urandom;
    end else begin
      mem_valid = s_stray;
      mem_read_data = $urandom;
    end
    winner = -1;
    if (cyc >= free_at) begin
      if (s_core.req && s_dma.req) winner = (last_served == 0) ? 1 : 0;
      else if (s_core.req) winner = 0;
      else if (s_dma.req) winner = 1;
    end
    acc = (winner >= 0) && s_mr && ((winner == 0) ? s_core.en : s_dma.en);
    if (winner == 1) ef = s_dma; else ef = s_core;
    #1;
    check("core_ready", 32'(core_ready), 32'(winner == 0 && s_mr));
    check("dma_ready", 32'(dma_ready), 32'(winner == 1 && s_mr));
    check("mem_enable", 32'(mem_enable), 32'(acc));
    check("mem_command", 32'(mem_command), 32'(ef.cmd));
    check("mem_address", mem_address, ef.addr);
    check("mem_write_data", mem_write_data, ef.wdata);
    check("mem_write_mask", 32'(mem_write_mask), 32'(ef.mask));
    if (mem_enable) begin
      n_mem_en++;
      dut_grants.push_back(dma_ready ? 1 : 0);
    end
    if (acc) begin
      l = (lat == 0) ? int'($urandom_range(1, 6)) : lat;
      resp_cycle = cyc + l;
      free_at = resp_cycle + 1;
      resp_data = (lat == 0) ? $urandom : rdata;
      last_served = winner;
      exp_q.push_back('{who: winner, err: (l > TO), data: resp_data,
                        due: cyc + ((l > TO) ? TO : l)});
    end
  endtask

  // Asynchronous reset in the middle of traffic, with all inputs active.
  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    reset_n = 1'b0;
    core_req = 1'b1; core_enable = 1'b1; dma_req = 1'b1; dma_enable = 1'b1;
    core_address = 32'hFFFF_FFFF; core_write_data = 32'hFFFF_FFFF; core_write_mask = 4'hF;
    core_command = 1'b1;
    mem_ready = 1'b1; mem_valid = 1'b1; mem_read_data = 32'hFFFF_FFFF;
    free_at = 0; last_served = 1;
    exp_q.delete();
    #1;
    check_all_zero("reset_busy");
    @(posedge clk); #1;
    cyc++;
    #1;
    check_all_zero("reset_hold");
    core_req = 1'b0; core_enable = 1'b0; dma_req = 1'b0; dma_enable = 1'b0;
    mem_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  // Completion monitor: every valid must match the oldest expected response.
  always @(negedge clk) begin
    if (core_valid || dma_valid) begin
      if (core_valid && dma_valid) begin
        check("both_valid", 32'({core_valid, dma_valid}), 32'd1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'({core_valid, dma_valid}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid_owner", 32'(dma_valid), 32'(mon_e.who));
        check("valid_cycle", 32'(cyc), 32'(mon_e.due));
        check("valid_error", 32'(core_error | dma_error), 32'(mon_e.err));
        if (!mon_e.err) check("read_data", read_data, mon_e.data);
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_valid: no valid, expected one for requester %0d at cycle %0d (now %0d)",
               mon_e.who, mon_e.due, cyc);
    end
  end

  initial begin
    int exp_seq[4] = '{0, 1, 0, 1};
    int n0;
    rq_t idle;
    idle = mk_rq(1'b0, 1'b0, MEM_READ, 32'h0, 32'h0, 4'h0);
    s_core = idle; s_dma = idle;

    // Reset with every input active: all outputs must stay low.
    reset_n = 1'b0;
    core_req = 1'b1; core_enable = 1'b1; core_command = 1'b1;
    core_address = 32'h1234_5678; core_write_data = 32'h8765_4321; core_write_mask = 4'hF;
    dma_req = 1'b1; dma_enable = 1'b1; dma_command = 1'b1;
    dma_address = 32'hAAAA_AAAA; dma_write_data = 32'h5555_5555; dma_write_mask = 4'hF;
    mem_ready = 1'b1; mem_valid = 1'b1; mem_read_data = 32'hCAFE_F00D;
    #2;
    check_all_zero("reset_init");
    @(posedge clk); #1;
    core_req = 1'b0; core_enable = 1'b0; dma_req = 1'b0; dma_enable = 1'b0; mem_valid = 1'b0;
    reset_n = 1'b1;

    // Contention from reset, 2-cycle transactions: core, dma, core, dma.
    s_core = mk_rq(1'b1, 1'b1, MEM_READ, 32'h200, 32'h0, 4'h0);
    s_dma  = mk_rq(1'b1, 1'b1, MEM_WRITE, 32'h300, 32'h1111_2222, 4'hC);
    dut_grants.delete();
    repeat (8) run_cycle(1, 32'h0000_1111);
    check("contention_count", 32'(dut_grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_grants.size()) check("contention_order", 32'(dut_grants[i]), 32'(exp_seq[i]));
    end
    s_core = idle; s_dma = idle;
    repeat (2) run_cycle(0, 32'h0);

    // Core-only read answered three cycles after acceptance.
    n0 = n_mem_en;
    s_core = mk_rq(1'b1, 1'b1, MEM_READ, 32'h100, 32'h0, 4'h0);
    run_cycle(3, 32'hDEAD_BEEF);
    s_core = idle;
    repeat (4) run_cycle(0, 32'h0);
    check("core_read_enables", 32'(n_mem_en - n0), 32'd1);

    // DMA partial write.
    s_dma = mk_rq(1'b1, 1'b1, MEM_WRITE, 32'h40, 32'h1234_5678, 4'b0011);
    run_cycle(2, 32'h0);
    s_dma = idle;
    repeat (3) run_cycle(0, 32'h0);

    // Watchdog: memory answers two cycles after the timeout; core keeps asking.
    n0 = dut_grants.size();
    s_core = mk_rq(1'b1, 1'b1, MEM_READ, 32'h500, 32'h0, 4'h0);
    run_cycle(6, 32'h0BAD_F00D);
    repeat (8) run_cycle(1, 32'h600D_0001);
    check("timeout_regrants", 32'(dut_grants.size() - n0), 32'd2);
    if (dut_grants.size() > 0) check("timeout_regrant_core", 32'(dut_grants[$]), 32'd0);
    s_core = idle;
    repeat (3) run_cycle(0, 32'h0);

    // Completion exactly on the timeout cycle wins, no error.
    s_core = mk_rq(1'b1, 1'b1, MEM_READ, 32'h600, 32'h0, 4'h0);
    run_cycle(TO, 32'hA5A5_5A5A);
    s_core = idle;
    repeat (5) run_cycle(0, 32'h0);

    // Memory not ready: no ready, no acceptance.
    n0 = n_mem_en;
    s_core = mk_rq(1'b1, 1'b1, MEM_WRITE, 32'h700, 32'h7777_7777, 4'hF);
    s_mr = 1'b0;
    repeat (3) run_cycle(0, 32'h0);
    check("no_ready_enables", 32'(n_mem_en - n0), 32'd0);
    s_mr = 1'b1;

    // Reset while busy, then a stray completion, then a fresh tie.
    run_cycle(6, 32'h0);
    repeat (2) run_cycle(0, 32'h0);
    do_reset();
    s_core = idle; s_dma = idle;
    s_stray = 1'b1;
    repeat (2) run_cycle(0, 32'h0);
    s_stray = 1'b0;
    dut_grants.delete();
    s_core = mk_rq(1'b1, 1'b1, MEM_READ, 32'h800, 32'h0, 4'h0);
    s_dma  = mk_rq(1'b1, 1'b1, MEM_READ, 32'h900, 32'h0, 4'h0);
    run_cycle(1, 32'h1357_9BDF);
    check("post_reset_grants", 32'(dut_grants.size()), 32'd1);
    if (dut_grants.size() > 0) check("post_reset_tie_core", 32'(dut_grants[0]), 32'd0);
    s_core = idle; s_dma = idle;
    repeat (3) run_cycle(0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      s_core = mk_rq($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      s_dma  = mk_rq($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      s_mr = $urandom_range(0, 4) != 0;
      s_stray = $urandom_range(0, 5) == 0;
      run_cycle(0, 32'h0);
    end
    s_core = idle; s_dma = idle; s_mr = 1'b1; s_stray = 1'b0;
    repeat (12) run_cycle(0, 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
